// File: rtl/ins_prefetch_queue.sv
// ins_prefetch_queue: sequential instruction prefetch into a DEPTH-entry {pc, data} FIFO with redirect flush.
// Define PREFETCH_STATS_EN to add the saturating fetch_count port.
module ins_prefetch_queue #(
   parameter int                ADDR_W   = 16,
   parameter int                DATA_W   = 8,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_en,
   input  logic              redirect_en,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              bus_rd_en,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_ready,
   output logic              ins_valid,
   output logic [DATA_W-1:0] ins_data,
   output logic [ADDR_W-1:0] ins_pc,
   input  logic              ins_pop
`ifdef PREFETCH_STATS_EN
   ,
   output logic [15:0]       fetch_count
`endif
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   typedef enum logic {IDLE, FETCH} state_t;
   state_t state, state_nx;

   logic [PW-1:0]     wptr, rptr;
   logic [PW:0]       count, count_nx;
   logic [ADDR_W-1:0] pc_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic              accept, push, pop;

   // bus_addr doubles as the fetch PC: it only advances on an accepted read
   assign bus_rd_en = state == FETCH;
   assign accept    = bus_rd_en && bus_ready;
   assign push      = accept && !redirect_en;
   assign pop       = ins_pop && ins_valid && !redirect_en;
   assign count_nx  = redirect_en ? '0 : count + (PW+1)'(push) - (PW+1)'(pop);
   assign ins_valid = count != '0;
   assign ins_data  = data_mem[rptr];
   assign ins_pc    = pc_mem[rptr];

   // a request is only launched when the word it returns is guaranteed a slot
   always_comb begin
      state_nx = IDLE;
      state_nx = ((state == FETCH) && (redirect_en || !accept)) || (fetch_en && count_nx != FULL) ? FETCH : IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         bus_addr <= RESET_PC;
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]   <= RESET_PC;
            data_mem[i] <= '0;
         end
      end else begin
         state <= state_nx;
         count <= count_nx;
         if (redirect_en) begin
            bus_addr <= redirect_pc;
            wptr     <= '0;
            rptr     <= '0;
         end else begin
            if (accept)
               bus_addr <= bus_addr + ADDR_W'(1);
            if (push) begin
               pc_mem[wptr]   <= bus_addr;
               data_mem[wptr] <= bus_rdata;
               wptr           <= wptr + PW'(1);
            end
            if (pop)
               rptr <= rptr + PW'(1);
         end
      end
   end

`ifdef PREFETCH_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         fetch_count <= '0;
      else if (push && fetch_count != 16'hFFFF)
         fetch_count <= fetch_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_ins_prefetch_queue.sv
// tb_ins_prefetch_queue: random and directed stimulus against a queue-based model of the fetched stream.
module tb_ins_prefetch_queue;
   localparam int DEPTH = 4;

   logic        clk = 0, rst_n = 0, fetch_en = 0, redirect_en = 0, bus_ready = 0, ins_pop = 0;
   logic [15:0] redirect_pc = 0, bus_addr, ins_pc;
   logic [7:0]  bus_rdata = 0, ins_data;
   logic        bus_rd_en, ins_valid;
`ifdef PREFETCH_STATS_EN
   logic [15:0] fetch_count;
`endif

   always #5 clk = ~clk;

   ins_prefetch_queue #(.ADDR_W(16), .DATA_W(8), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
      .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
      .bus_addr(bus_addr), .bus_rd_en(bus_rd_en), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
      .ins_valid(ins_valid), .ins_data(ins_data), .ins_pc(ins_pc), .ins_pop(ins_pop)
`ifdef PREFETCH_STATS_EN
      , .fetch_count(fetch_count)
`endif
   );

   typedef struct packed {logic [15:0] pc; logic [7:0] data;} ent_t;
   typedef struct packed {logic valid; logic full; logic [15:0] pc; logic [7:0] data;} exp_t;

   ent_t        q[$];
   exp_t        sb[$];
   exp_t        me;
   logic [15:0] exp_pc = 0;
   int          errors = 0, checks = 0, n_acc = 0, n_push = 0, base;
   bit          prev_wait = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // drive one cycle of inputs and predict the decoder-visible state after the coming edge
   task automatic step(input bit fe, input bit rd, input logic [15:0] rpc, input bit rdy, input bit pop);
      exp_t e;
      @(negedge clk);
      fetch_en = fe; redirect_en = rd; redirect_pc = rpc; bus_ready = rdy; ins_pop = pop;
      bus_rdata = 8'($urandom);
      if (prev_wait) chk("held_req", bus_rd_en, 1);
      if (rd) begin
         q.delete();
         exp_pc = rpc;
      end else begin
         if (pop && q.size() > 0) void'(q.pop_front());
         if (bus_rd_en && rdy) begin
            chk("accept_addr", bus_addr, exp_pc);
            q.push_back({exp_pc, bus_rdata});
            exp_pc++;
            n_acc++;
            n_push++;
         end
      end
      prev_wait = bus_rd_en && !rdy;
      e.valid = q.size() > 0;
      e.full  = q.size() == DEPTH;
      e.pc    = e.valid ? q[0].pc : 16'h0;
      e.data  = e.valid ? q[0].data : 8'h0;
      sb.push_back(e);
   endtask

   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         me = sb.pop_front();
         chk("ins_valid", ins_valid, me.valid);
         if (me.valid) begin
            chk("ins_pc", ins_pc, me.pc);
            chk("ins_data", ins_data, me.data);
         end
         if (me.full) chk("full_no_req", bus_rd_en, 0);
      end
   end

   initial begin
      #12;
      chk("rst_rd_en", bus_rd_en, 0);
      chk("rst_addr", bus_addr, 0);
      chk("rst_valid", ins_valid, 0);
      chk("rst_data", ins_data, 0);
      chk("rst_pc", ins_pc, 0);
      @(negedge clk) rst_n = 1;

      // fill: four back-to-back accepts, then the request drops
      repeat (5) step(1, 0, 0, 1, 0);
      chk("fill_accepts", n_acc, 4);
      step(1, 0, 0, 1, 0);
      chk("fill_stop", bus_rd_en, 0);
      repeat (4) step(1, 0, 0, 0, 1);
      repeat (2) step(1, 0, 0, 0, 0);

      // asynchronous reset with a read pending
      @(posedge clk); #2;
      chk("pre_rst_req", bus_rd_en, 1);
      rst_n = 0; fetch_en = 0;
      #1;
      chk("arst_rd_en", bus_rd_en, 0);
      chk("arst_addr", bus_addr, 0);
      chk("arst_valid", ins_valid, 0);
      q.delete(); exp_pc = 0; prev_wait = 0; n_push = 0;
      @(negedge clk) rst_n = 1;

      // wait states at 0x0010
      step(1, 1, 16'h0010, 0, 0);
      repeat (3) step(1, 0, 0, 0, 0);
      chk("wait_addr", bus_addr, 16'h0010);
      base = n_acc;
      step(1, 0, 0, 1, 0);
      repeat (2) step(0, 0, 0, 0, 0);
      chk("wait_one_push", n_acc - base, 1);

      // redirect while a word is being accepted
      step(1, 1, 16'h0020, 1, 0);
      repeat (3) step(1, 0, 0, 1, 0);
      step(1, 1, 16'h0100, 1, 0);
      step(1, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      chk("redir_head", ins_pc, 16'h0100);
      repeat (3) step(0, 0, 0, 0, 1);

      // PC wrap, then popping an empty queue
      step(1, 1, 16'hFFFE, 1, 0);
      repeat (4) step(1, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      repeat (4) step(0, 0, 0, 0, 1);
      repeat (2) step(0, 0, 0, 0, 1);

      repeat (1500) begin
         step($urandom_range(0, 9) < 8, $urandom_range(0, 31) == 0,
              $urandom_range(0, 3) == 0 ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom),
              $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1);
      end
      step(0, 0, 0, 0, 0);
      @(posedge clk); #2;
      chk("sb_drained", sb.size(), 0);
`ifdef PREFETCH_STATS_EN
      chk("fetch_count", fetch_count, n_push);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
